hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline interlock and forwarding controller for the 5-stage pipelined DLX, successor to the single-cycle control decoder.
- Takes the decoded ID-stage register usage and the EX-stage branch outcome.
- Tracks in-flight destinations (GPR and FPR) through EX/MEM/WB internally.
- Generates stall, bubble, flush and forwarding selects.
- Adds a multi-cycle FPU (MULTF/DIVF etc.) busy interlock with parametrised latency.

Parameters:
REG_AW, 5, register-specifier width (GPR and FPR files alike)
FPU_LAT, 4, cycles a long FPU op occupies the FPU; legal range 2..15

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1, id_rs2  in  REG_AW  source specifiers
id_use_rs1, id_use_rs2  in  1  source actually read
id_rs1_fp, id_rs2_fp  in  1  source is FPR (else GPR)
id_rd  in  REG_AW  destination specifier
id_rd_fp  in  1  destination is FPR
id_regwe  in  1  instruction writes a register
id_load  in  1  instruction is a load (MEMInst)
id_fpu  in  1  instruction uses the FPU
id_fpu_long  in  1  multi-cycle FPU op (subset of id_fpu)
ex_branch_taken  in  1  branch/jump in EX redirects the PC this cycle
stall_if_id  out  1  hold PC and IF/ID register
bubble_ex  out  1  load NOP into ID/EX
flush_if_id  out  1  squash IF/ID contents
fwd_a, fwd_b  out  2  operand select: 00 register file, 01 EX/MEM, 10 MEM/WB
fpu_busy  out  1  long FPU op in progress

Behaviour:
- Tracking entries EX, MEM, WB: each holds {valid, rd, fp, regwe, load}. Reset clears all valid bits.
  - Every cycle: WB <= MEM, MEM <= EX.
  - EX <= ID entry if id_valid & !bubble_ex & !id_fpu_long; otherwise EX <= invalid.
  - Long ops do not enter EX tracking. Their destination is held in fpu_rd/fpu_rd_fp.
- Match rule: entry valid & regwe & rd == src & fp == src_fp & src used. A GPR r0 source never matches; FPR f0 does.
- Load-use stall: the EX entry is a load and matches rs1 or rs2 → stall_if_id=1, bubble_ex=1 for one cycle.
- FPU counter: 4-bit count register.
  - Loads FPU_LAT-1 when id_valid & id_fpu_long & no stall & no flush.
  - Decrements to 0 otherwise.
  - fpu_busy = (count != 0), registered. It asserts the cycle after issue and holds FPU_LAT-1 cycles.
- FPU stalls while fpu_busy:
  - id_fpu → stall (structural).
  - Any used source matching fpu_rd/fpu_rd_fp → stall (RAW).
  - id_regwe writing fpu_rd/fpu_rd_fp → stall (WAW).
- The register file is write-before-read, so no forwarding is needed from the FPU result.
- Forwarding (combinational):
  - fwd_x = 01 if the EX entry matches and is not a load.
  - Else fwd_x = 10 if the MEM entry matches.
  - Else fwd_x = 00.
  - The youngest producer wins.
- Flush: ex_branch_taken → flush_if_id=1, bubble_ex=1, stall_if_id=0. Flush overrides every stall. The FPU counter is not loaded that cycle.
- Combined stall conditions OR together. stall_if_id implies bubble_ex.
- Reset values: all outputs 0, count 0, tracking invalid. Reset mid-long-op drops fpu_busy immediately.
- Outputs other than fpu_busy are combinational from inputs and state.

Optional Feature:
- HAZARD_FWD_EN defined: forwarding as above.
- Undefined:
  - fwd_a/fwd_b tied to 00.
  - Any match against a valid EX or MEM entry (loads or not) stalls with a bubble.
  - WB is covered by the write-before-read register file.

Decomposition:
- Package hazard_pkg holds:
  - FWD_REG/FWD_EXMEM/FWD_MEMWB constants
  - track_entry_t struct {valid, rd, fp, regwe, load}
  - src_match function
- Sub-module fpu_lat_counter (load, dec, busy; parametrised FPU_LAT).

Test Plan:
- ADD r3 in EX, ID reads r3 (GPR) → fwd_a=01, no stall. Next cycle r3 is in MEM → fwd_a=10.
- LW r5 in EX, ID ADD reads r5 on rs2 → stall_if_id=1, bubble_ex=1 for one cycle; then fwd_b=10.
- ID reads r0 while EX writes r0 → fwd 00, no stall. Same case with FPR f0 → fwd 01.
- MULTF f2 issued with FPU_LAT=4 → fpu_busy high 3 cycles. A following ADDF reading f2 stalls 3 cycles; a GPR ADD does not stall.
- Load-use stall coincident with ex_branch_taken → flush_if_id=1, bubble_ex=1, stall_if_id=0.
- Without HAZARD_FWD_EN: ADD r3 then SUB reading r3 → 2 stall cycles, fwd always 00. Reset asserted during busy → all outputs 0 asynchronously.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the DLX pipeline interlock/forwarding controller.
package hazard_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Tracking entries carry a fixed-width specifier; REG_AW at the top must not exceed this.
    localparam int TRK_AW = 8;

    typedef struct packed {
        logic              valid;
        logic [TRK_AW-1:0] rd;
        logic              fp;
        logic              regwe;
        logic              load;
    } track_entry_t;

    // GPR r0 is hard-wired zero and never produces a hazard; FPR f0 is a real register.
    function automatic logic src_match(input track_entry_t e, input logic [TRK_AW-1:0] src,
                                       input logic src_fp, input logic used);
        return used & e.valid & e.regwe & (e.rd == src) & (e.fp == src_fp) &
               (src_fp | (src != '0));
    endfunction

endpackage

// File: rtl/hazard_ctrl_fpu_lat_counter.sv
// Busy timer for long FPU ops: loads FPU_LAT-1 on issue, counts down to zero.
module fpu_lat_counter #(
    parameter int FPU_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic busy
);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= 4'(FPU_LAT - 1);
        else if (dec && count != '0)
            count <= count - 4'd1;
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Interlock/forwarding controller for the 5-stage DLX pipeline with FPU busy interlock.
// Define HAZARD_FWD_EN to enable EX/MEM and MEM/WB forwarding; otherwise RAW hazards stall.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int FPU_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_rs1_fp,
    input  logic              id_rs2_fp,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_fp,
    input  logic              id_regwe,
    input  logic              id_load,
    input  logic              id_fpu,
    input  logic              id_fpu_long,
    input  logic              ex_branch_taken,
    output logic              stall_if_id,
    output logic              bubble_ex,
    output logic              flush_if_id,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              fpu_busy
);

    track_entry_t      ex_e, mem_e, wb_e, id_e, fpu_e;
    logic [REG_AW-1:0] fpu_rd;
    logic              fpu_rd_fp;
    logic [TRK_AW-1:0] rs1_x, rs2_x, rd_x;
    logic              ex_m1, ex_m2, mem_m1, mem_m2, fpu_m1, fpu_m2;
    logic              load_use, fpu_stall, data_stall, hazard, fpu_load;

    assign rs1_x = TRK_AW'(id_rs1);
    assign rs2_x = TRK_AW'(id_rs2);
    assign rd_x  = TRK_AW'(id_rd);

    assign id_e  = '{valid: id_valid, rd: rd_x, fp: id_rd_fp, regwe: id_regwe, load: id_load};
    assign fpu_e = '{valid: fpu_busy, rd: TRK_AW'(fpu_rd), fp: fpu_rd_fp, regwe: 1'b1, load: 1'b0};

    assign ex_m1  = src_match(ex_e,  rs1_x, id_rs1_fp, id_use_rs1);
    assign ex_m2  = src_match(ex_e,  rs2_x, id_rs2_fp, id_use_rs2);
    assign mem_m1 = src_match(mem_e, rs1_x, id_rs1_fp, id_use_rs1);
    assign mem_m2 = src_match(mem_e, rs2_x, id_rs2_fp, id_use_rs2);
    assign fpu_m1 = src_match(fpu_e, rs1_x, id_rs1_fp, id_use_rs1);
    assign fpu_m2 = src_match(fpu_e, rs2_x, id_rs2_fp, id_use_rs2);

    assign load_use  = ex_e.load & (ex_m1 | ex_m2);
    // Structural, RAW and WAW against the long op all hold ID until the FPU drains.
    assign fpu_stall = fpu_busy & (id_fpu | fpu_m1 | fpu_m2 |
                       (id_regwe & (rd_x == fpu_e.rd) & (id_rd_fp == fpu_rd_fp)));

`ifdef HAZARD_FWD_EN
    assign data_stall = 1'b0;
    assign fwd_a = (ex_m1 & ~ex_e.load) ? FWD_EXMEM : mem_m1 ? FWD_MEMWB : FWD_REG;
    assign fwd_b = (ex_m2 & ~ex_e.load) ? FWD_EXMEM : mem_m2 ? FWD_MEMWB : FWD_REG;
`else
    assign data_stall = ex_m1 | ex_m2 | mem_m1 | mem_m2;
    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;
`endif

    assign hazard      = id_valid & (load_use | fpu_stall | data_stall);
    assign flush_if_id = ex_branch_taken;
    assign stall_if_id = hazard & ~ex_branch_taken;
    assign bubble_ex   = hazard | ex_branch_taken;
    assign fpu_load    = id_valid & id_fpu_long & ~hazard & ~ex_branch_taken;

    // Long ops bypass EX tracking; their destination lives in fpu_rd while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_e      <= '0;
            mem_e     <= '0;
            wb_e      <= '0;
            fpu_rd    <= '0;
            fpu_rd_fp <= 1'b0;
        end else begin
            ex_e  <= (id_valid & ~bubble_ex & ~id_fpu_long) ? id_e : '0;
            mem_e <= ex_e;
            wb_e  <= mem_e;
            if (fpu_load) begin
                fpu_rd    <= id_rd;
                fpu_rd_fp <= id_rd_fp;
            end
        end
    end

    // WB is tracked for completeness; the write-before-read file makes it hazard-free.
    logic unused_trk;
    assign unused_trk = ^{wb_e, mem_e.load};

    fpu_lat_counter #(.FPU_LAT(FPU_LAT)) u_fpu_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (fpu_load),
        .dec  (1'b1),
        .busy (fpu_busy)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl; expectations follow the HAZARD_FWD_EN build setting.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1, rs2;
        logic       u1, u2, f1, f2;
        logic [4:0] rd;
        logic       rdfp, regwe, load, fpu, lng;
    } id_t;

    typedef struct {
        logic [6:0] v;
        string      name;
    } sb_t;

    logic clk = 1'b0, rst = 1'b1;
    id_t  id = '0;
    logic br = 1'b0;
    logic stall_if_id, bubble_ex, flush_if_id, fpu_busy;
    logic [1:0] fwd_a, fwd_b;

    sb_t q[$];
    int  n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .FPU_LAT(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id.valid),
        .id_rs1(id.rs1), .id_rs2(id.rs2), .id_use_rs1(id.u1), .id_use_rs2(id.u2),
        .id_rs1_fp(id.f1), .id_rs2_fp(id.f2), .id_rd(id.rd), .id_rd_fp(id.rdfp),
        .id_regwe(id.regwe), .id_load(id.load), .id_fpu(id.fpu), .id_fpu_long(id.lng),
        .ex_branch_taken(br), .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
        .flush_if_id(flush_if_id), .fwd_a(fwd_a), .fwd_b(fwd_b), .fpu_busy(fpu_busy)
    );

    function automatic id_t alu(input int rd, input int a, input int b);
        id_t i = '0;
        i.valid = 1; i.regwe = 1; i.rd = 5'(rd);
        i.rs1 = 5'(a); i.u1 = 1; i.rs2 = 5'(b); i.u2 = 1;
        return i;
    endfunction

    function automatic id_t fop(input int rd, input int a, input int b, input logic lng);
        id_t i = alu(rd, a, b);
        i.rdfp = 1; i.f1 = 1; i.f2 = 1; i.fpu = 1; i.lng = lng;
        return i;
    endfunction

    function automatic id_t ld(input int rd, input int a, input logic fp);
        id_t i = '0;
        i.valid = 1; i.regwe = 1; i.load = 1; i.rd = 5'(rd); i.rdfp = fp;
        i.rs1 = 5'(a); i.u1 = 1;
        return i;
    endfunction

    // {stall, bubble, flush, fwd_a, fwd_b, busy}
    function automatic logic [6:0] ex(input logic s, input logic b, input logic f,
                                      input logic [1:0] fa, input logic [1:0] fb, input logic bz);
        return {s, b, f, fa, fb, bz};
    endfunction

    task automatic step(input id_t i, input logic brk, input logic r, input logic [6:0] e,
                        input string name);
        sb_t s;
        @(posedge clk);
        #1;
        rst = r; id = i; br = brk;
        s.v = e; s.name = name;
        q.push_back(s);
    endtask

    initial begin : monitor
        sb_t s;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                s = q.pop_front();
                act = {stall_if_id, bubble_ex, flush_if_id, fwd_a, fwd_b, fpu_busy};
                n_total++;
                if (act === s.v) n_pass++;
                else $display("FAIL %s: got s/b/f=%b%b%b fa=%b fb=%b busy=%b, want s/b/f=%b%b%b fa=%b fb=%b busy=%b",
                              s.name, act[6], act[5], act[4], act[3:2], act[1:0], act[0],
                              s.v[6], s.v[5], s.v[4], s.v[3:2], s.v[1:0], s.v[0]);
            end
        end
    end

    initial begin : driver
        id_t nop = '0;
        step(nop, 0, 1, ex(0,0,0,0,0,0), "reset_state");
        step(alu(3,1,2), 0, 0, ex(0,0,0,0,0,0), "add_r3_issue");
`ifdef HAZARD_FWD_EN
        step(alu(4,3,1), 0, 0, ex(0,0,0,2'b01,0,0), "fwd_exmem_a");
        step(alu(6,3,4), 0, 0, ex(0,0,0,2'b10,2'b01,0), "fwd_memwb_a_exmem_b");
        step(ld(5,1,0), 0, 0, ex(0,0,0,0,0,0), "lw_issue");
        step(alu(7,1,5), 0, 0, ex(1,1,0,0,0,0), "load_use_stall");
        step(alu(7,1,5), 0, 0, ex(0,0,0,0,2'b10,0), "load_use_fwd_b");
        step(alu(0,1,1), 0, 0, ex(0,0,0,0,0,0), "wr_r0_issue");
        step(alu(8,0,0), 0, 0, ex(0,0,0,0,0,0), "r0_no_match");
        step(fop(0,1,1,0), 0, 0, ex(0,0,0,0,0,0), "wr_f0_issue");
        step(fop(1,0,3,0), 0, 0, ex(0,0,0,2'b01,0,0), "f0_fwd");
        step(alu(10,1,1), 0, 0, ex(0,0,0,0,0,0), "r10_a");
        step(alu(10,1,1), 0, 0, ex(0,0,0,0,0,0), "r10_b");
        step(alu(11,10,10), 0, 0, ex(0,0,0,2'b01,2'b01,0), "youngest_wins");
`else
        step(alu(4,3,1), 0, 0, ex(1,1,0,0,0,0), "nofwd_ex_stall");
        step(alu(4,3,1), 0, 0, ex(1,1,0,0,0,0), "nofwd_mem_stall");
        step(alu(4,3,1), 0, 0, ex(0,0,0,0,0,0), "nofwd_wb_free");
        step(ld(5,1,0), 0, 0, ex(0,0,0,0,0,0), "lw_issue");
        step(alu(7,1,5), 0, 0, ex(1,1,0,0,0,0), "load_use_stall");
        step(alu(7,1,5), 0, 0, ex(1,1,0,0,0,0), "load_mem_stall");
        step(alu(7,1,5), 0, 0, ex(0,0,0,0,0,0), "load_wb_free");
        step(alu(0,1,1), 0, 0, ex(0,0,0,0,0,0), "wr_r0_issue");
        step(alu(8,0,0), 0, 0, ex(0,0,0,0,0,0), "r0_no_match");
        step(fop(0,1,1,0), 0, 0, ex(0,0,0,0,0,0), "wr_f0_issue");
        step(fop(1,0,3,0), 0, 0, ex(1,1,0,0,0,0), "f0_ex_stall");
        step(fop(1,0,3,0), 0, 0, ex(1,1,0,0,0,0), "f0_mem_stall");
        step(fop(1,0,3,0), 0, 0, ex(0,0,0,0,0,0), "f0_free");
`endif
        step(fop(2,4,5,1), 0, 0, ex(0,0,0,0,0,0), "multf_issue");
        step(fop(6,2,7,0), 0, 0, ex(1,1,0,0,0,1), "fpu_stall_1");
        step(fop(6,2,7,0), 0, 0, ex(1,1,0,0,0,1), "fpu_stall_2");
        step(fop(6,2,7,0), 0, 0, ex(1,1,0,0,0,1), "fpu_stall_3");
        step(fop(6,2,7,0), 0, 0, ex(0,0,0,0,0,0), "fpu_drained");
        step(fop(2,4,5,1), 0, 0, ex(0,0,0,0,0,0), "multf_issue2");
        step(alu(12,1,2), 0, 0, ex(0,0,0,0,0,1), "gpr_add_no_stall");
        step(ld(2,1,1), 0, 0, ex(1,1,0,0,0,1), "waw_stall");
        step(fop(6,2,7,0), 1, 0, ex(0,1,1,0,0,1), "flush_over_fpu");
        step(ld(5,1,0), 0, 0, ex(0,0,0,0,0,0), "lw_issue2");
        step(alu(7,5,5), 1, 0, ex(0,1,1,0,0,0), "flush_over_load_use");
        step(fop(2,4,5,1), 1, 0, ex(0,1,1,0,0,0), "flush_blocks_fpu_load");
        step(nop, 0, 0, ex(0,0,0,0,0,0), "fpu_not_loaded");
        step(fop(2,4,5,1), 0, 0, ex(0,0,0,0,0,0), "multf_issue3");
        step(nop, 0, 0, ex(0,0,0,0,0,1), "busy_before_reset");
        step(nop, 0, 1, ex(0,0,0,0,0,0), "async_reset_busy");
        step(nop, 0, 0, ex(0,0,0,0,0,0), "post_reset");
        repeat (4) @(posedge clk);
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
